ps2_scancode_rx: RTL and testbench

PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

---
 rtl/ps2_scancode_rx.sv | 171 +++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: pad synchronizers, glitch filters, frame FSM and a
// scancode decoder that folds E0/F0 prefixes into one key event.
module ps2_scancode_rx #(
  parameter int unsigned TIMEOUT_CYC = 12000,
  parameter int unsigned FILT_LEN    = 8
) (
  input  logic       clk12,
  input  logic       rst,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned FW = $clog2(FILT_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [1:0]     r_clk_s;
  logic [1:0]     r_dat_s;
  logic           r_clk_f;
  logic           r_dat_f;
  logic           r_clk_f_d;
  logic [FW-1:0]  r_clk_cnt;
  logic [FW-1:0]  r_dat_cnt;
  logic [TW-1:0]  r_to_cnt;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_par;
  logic           r_ext;
  logic           r_rel;
  logic           w_fall;
  logic           w_tout;
  logic           w_emit;
  logic           w_err;
  logic           w_event;

  // Synchronize both pads, then require FILT_LEN agreeing samples before a filtered line flips
  always_ff @(posedge clk12) begin
    if (rst) begin
      r_clk_s   <= 2'b11;
      r_dat_s   <= 2'b11;
      r_clk_f   <= 1'b1;
      r_dat_f   <= 1'b1;
      r_clk_f_d <= 1'b1;
      r_clk_cnt <= '0;
      r_dat_cnt <= '0;
    end else begin
      r_clk_s   <= {r_clk_s[0], ps2clk_in};
      r_dat_s   <= {r_dat_s[0], ps2data_in};
      r_clk_f_d <= r_clk_f;
      if (r_clk_s[1] == r_clk_f) begin
        r_clk_cnt <= '0;
      end else if (r_clk_cnt == FW'(FILT_LEN - 1)) begin
        r_clk_f   <= r_clk_s[1];
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + FW'(1);
      end
      if (r_dat_s[1] == r_dat_f) begin
        r_dat_cnt <= '0;
      end else if (r_dat_cnt == FW'(FILT_LEN - 1)) begin
        r_dat_f   <= r_dat_s[1];
        r_dat_cnt <= '0;
      end else begin
        r_dat_cnt <= r_dat_cnt + FW'(1);
      end
    end
  end

  assign w_fall  = r_clk_f_d & ~r_clk_f;
  assign w_tout  = (r_state != S_IDLE) && !w_fall && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_event = w_emit && (r_shift != 8'hE0) && (r_shift != 8'hF0);

  always_ff @(posedge clk12) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE:   if (w_fall && !r_dat_f) w_state_nxt = S_DATA;
      S_DATA:   if (w_fall && r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
      S_PARITY: if (w_fall) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_fall) begin
          // Stop must be 1 and data+parity must carry odd parity
          if (r_dat_f && ^{r_shift, r_par}) w_emit = 1'b1;
          else                              w_err  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_tout) w_state_nxt = S_IDLE;
  end

  // Frame datapath, prefix decoder and the single-entry event holding register
  always_ff @(posedge clk12) begin
    if (rst) begin
      r_to_cnt     <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_ext        <= 1'b0;
      r_rel        <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      key_valid    <= 1'b0;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
      ps2clk_oe    <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_fall) r_to_cnt <= '0;
      else                             r_to_cnt <= r_to_cnt + TW'(1);

      if (w_fall) begin
        case (r_state)
          S_IDLE:   r_bit_cnt <= '0;
          S_DATA: begin
            r_shift   <= {r_dat_f, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          S_PARITY: r_par <= r_dat_f;
          default:  ;
        endcase
      end

      if (w_emit) begin
        if (r_shift == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_rel <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_rel <= 1'b0;
        end
      end

      if (w_event) begin
        if (!key_valid || key_ack) begin
          key_code     <= r_shift;
          key_extended <= r_ext;
          key_released <= r_rel;
          key_valid    <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_ack && key_valid) begin
        key_valid <= 1'b0;
      end

      frame_err <= w_err;
      ps2clk_oe <= key_valid && (r_state == S_IDLE);
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: table of whole frames plus hand-written
// timeout, glitch, overrun/ack-collision and mid-frame reset sequences.
module tb_ps2_scancode_rx;

  localparam int unsigned TO  = 300;
  localparam int unsigned FL  = 4;
  localparam int unsigned HB  = 20;
  localparam int unsigned LAT = 2 + FL + 1;

  logic       clk12 = 1'b0;
  logic       rst;
  logic       ps2clk_in;
  logic       ps2data_in;
  logic       ps2clk_oe;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       key_valid;
  logic       key_ack;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int err_cnt = 0;
  int drop_cnt = 0;
  logic watch = 1'b0;

  always #5 clk12 = ~clk12;

  ps2_scancode_rx #(.TIMEOUT_CYC(TO), .FILT_LEN(FL)) u_dut (
    .clk12        (clk12),
    .rst          (rst),
    .ps2clk_in    (ps2clk_in),
    .ps2data_in   (ps2data_in),
    .ps2clk_oe    (ps2clk_oe),
    .key_code     (key_code),
    .key_extended (key_extended),
    .key_released (key_released),
    .key_valid    (key_valid),
    .key_ack      (key_ack),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always @(posedge clk12) if (frame_err) err_cnt <= err_cnt + 1;
  always @(negedge clk12) if (watch && !key_valid) drop_cnt <= drop_cnt + 1;

  typedef struct {
    logic [7:0] code;
    logic       pflip;
    logic       stop;
    logic       exp_v;
    logic [7:0] exp_code;
    logic       exp_e;
    logic       exp_r;
    int         exp_err;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk12);
    #1;
  endtask

  // One device bit: data set during clock high, then a low phase
  task automatic bit_out(input logic b, input logic ack_at_fall);
    ps2data_in = b;
    cyc(HB);
    ps2clk_in = 1'b0;
    if (ack_at_fall) begin
      cyc(LAT - 1);
      key_ack = 1'b1;
      cyc(1);
      key_ack = 1'b0;
      cyc(HB - LAT);
    end else begin
      cyc(HB);
    end
    ps2clk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic pflip, input logic stop,
                            input logic ack_stop);
    logic [10:0] bits;
    bits = {stop, (~^code) ^ pflip, code, 1'b0};
    for (int i = 0; i < 11; i++) bit_out(bits[i], ack_stop && (i == 10));
    ps2data_in = 1'b1;
    cyc(HB);
  endtask

  task automatic send_partial(input logic [7:0] code, input int n);
    bit_out(1'b0, 1'b0);
    for (int i = 0; i < n; i++) bit_out(code[i], 1'b0);
    ps2data_in = 1'b1;
  endtask

  task automatic do_ack();
    key_ack = 1'b1;
    cyc(1);
    key_ack = 1'b0;
    cyc(2);
  endtask

  initial begin
    int e0;
    int d0;
    vt[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 0};
    vt[1] = '{8'hE0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vt[2] = '{8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0};
    vt[3] = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1, 0};
    vt[4] = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b0, 1'b0, 0};
    vt[5] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1};
    vt[6] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1};
    vt[7] = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 0};

    rst = 1'b1; ps2clk_in = 1'b1; ps2data_in = 1'b1; key_ack = 1'b0;
    cyc(5);
    chk("rst_valid", 32'(key_valid), 32'(0));
    chk("rst_code", 32'(key_code), 32'(0));
    chk("rst_ext_rel", 32'({key_extended, key_released}), 32'(0));
    chk("rst_err_ovr_oe", 32'({frame_err, overrun, ps2clk_oe}), 32'(0));
    rst = 1'b0;
    cyc(20);

    for (int i = 0; i < 8; i++) begin
      e0 = err_cnt;
      send_frame(vt[i].code, vt[i].pflip, vt[i].stop, 1'b0);
      chk($sformatf("v%0d_valid", i), 32'(key_valid), 32'(vt[i].exp_v));
      chk($sformatf("v%0d_err", i), 32'(err_cnt - e0), 32'(vt[i].exp_err));
      if (vt[i].exp_v) begin
        chk($sformatf("v%0d_code", i), 32'(key_code), 32'(vt[i].exp_code));
        chk($sformatf("v%0d_ext", i), 32'(key_extended), 32'(vt[i].exp_e));
        chk($sformatf("v%0d_rel", i), 32'(key_released), 32'(vt[i].exp_r));
        chk($sformatf("v%0d_oe_hi", i), 32'(ps2clk_oe), 32'(1));
        do_ack();
        chk($sformatf("v%0d_ack_valid", i), 32'(key_valid), 32'(0));
        chk($sformatf("v%0d_ack_oe", i), 32'(ps2clk_oe), 32'(0));
        chk($sformatf("v%0d_ack_code", i), 32'(key_code), 32'(vt[i].exp_code));
      end
    end

    // Aborted frame followed by a clean 0x29
    e0 = err_cnt;
    send_partial(8'h29, 4);
    cyc(TO * 3 / 2);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    chk("to_err", 32'(err_cnt - e0), 32'(0));
    chk("to_valid", 32'(key_valid), 32'(1));
    chk("to_code", 32'(key_code), 32'(8'h29));
    do_ack();

    // Short clock glitches must not start a frame
    e0 = err_cnt;
    ps2data_in = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ps2clk_in = 1'b0; cyc(3);
      ps2clk_in = 1'b1; cyc(10);
    end
    ps2data_in = 1'b1;
    cyc(20);
    chk("gl_quiet", 32'({key_valid, overrun}), 32'(0));
    send_frame(8'h4D, 1'b0, 1'b1, 1'b0);
    chk("gl_err", 32'(err_cnt - e0), 32'(0));
    chk("gl_code", 32'(key_code), 32'(8'h4D));
    chk("gl_valid", 32'(key_valid), 32'(1));
    do_ack();

    // Overrun, then an ack landing in the event cycle
    send_frame(8'h16, 1'b0, 1'b1, 1'b0);
    chk("ov_pre", 32'(overrun), 32'(0));
    send_frame(8'h1E, 1'b0, 1'b1, 1'b0);
    chk("ov_code", 32'(key_code), 32'(8'h16));
    chk("ov_flag", 32'(overrun), 32'(1));
    chk("ov_valid", 32'(key_valid), 32'(1));
    d0 = drop_cnt;
    watch = 1'b1;
    send_frame(8'h26, 1'b0, 1'b1, 1'b1);
    watch = 1'b0;
    chk("col_code", 32'(key_code), 32'(8'h26));
    chk("col_valid", 32'(key_valid), 32'(1));
    chk("col_no_drop", 32'(drop_cnt - d0), 32'(0));
    do_ack();
    chk("ov_sticky", 32'(overrun), 32'(1));
    chk("ov_ack_valid", 32'(key_valid), 32'(0));

    // Reset in the middle of a frame after an E0 prefix
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    e0 = err_cnt;
    send_partial(8'h75, 5);
    rst = 1'b1;
    cyc(3);
    chk("mr_valid", 32'(key_valid), 32'(0));
    chk("mr_code", 32'(key_code), 32'(0));
    chk("mr_flags", 32'({key_extended, key_released}), 32'(0));
    chk("mr_ovr_oe", 32'({overrun, ps2clk_oe, frame_err}), 32'(0));
    rst = 1'b0;
    cyc(TO + 50);
    chk("mr_quiet", 32'(key_valid), 32'(0));
    chk("mr_noerr", 32'(err_cnt - e0), 32'(0));
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("mr_next_code", 32'(key_code), 32'(8'h1C));
    chk("mr_next_ext", 32'(key_extended), 32'(0));
    chk("mr_next_valid", 32'(key_valid), 32'(1));
    do_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
